// File: rtl/fwd_source_pkg.sv
// rtl/fwd_source_pkg.sv - shared types and defaults for the EX/MEM forwarding producer
package fwd_source_pkg;

    // Common core defaults
    localparam int NREG_DEF  = 32;
    localparam int WORD_W    = 32;

    // Pipe defaults
    localparam int REG_AW    = 5;
    localparam int CNT_W_DEF = 2;

    typedef logic [WORD_W-1:0]    word_t;
    typedef logic [REG_AW-1:0]    creg_addr_t;
    typedef logic [CNT_W_DEF-1:0] sb_cnt_t;

    // One forwarding bus: a result heading for register dst
    typedef struct packed {
        logic       valid;
        creg_addr_t dst;
        word_t      data;
    } fwd_data_t;

    // True when a bus currently carries a usable value for register r
    function automatic logic bus_hit(input fwd_data_t bus, input creg_addr_t r);
        return bus.valid && (bus.dst == r);
    endfunction

endpackage

// File: rtl/fwd_source_if.sv
// rtl/fwd_source_if.sv - decode-side operand request and forwarding bus bundle
interface fwd_source_if;
    import fwd_source_pkg::*;

    // Decode operand request
    logic       id_valid;
    creg_addr_t id_rs1;
    creg_addr_t id_rs2;
    logic       id_use_rs2;

    // Forwarding buses and the decode hold
    fwd_data_t  ex_fwd;
    fwd_data_t  mem_fwd;
    logic       stall_id;

    // Producer side (fwd_source)
    modport master (
        input  id_valid, id_rs1, id_rs2, id_use_rs2,
        output ex_fwd, mem_fwd, stall_id
    );

    // Consumer side (decode operand mux)
    modport slave (
        output id_valid, id_rs1, id_rs2, id_use_rs2,
        input  ex_fwd, mem_fwd, stall_id
    );

endinterface

// File: rtl/fwd_source_scoreboard.sv
// rtl/fwd_source_scoreboard.sv - per-register pending-write counters and pending vector
module fwd_scoreboard
    import fwd_source_pkg::*;
#(
    parameter int NREG  = NREG_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inc_en,
    input  creg_addr_t      inc_dst,
    input  logic            wb_dec,
    input  creg_addr_t      wb_dst,
    input  logic            fl_dec,
    input  creg_addr_t      fl_dst,
    output logic [NREG-1:0] pending
);

    localparam int CMAX = (1 << CNT_W) - 1;

    logic [CNT_W-1:0] cnt     [NREG];
    logic [CNT_W-1:0] cnt_nxt [NREG];
    logic [NREG-1:0]  sat_err;

    // Net change per register: all three sources summed, then clamped to the counter range
    always_comb begin
        int delta;
        int sum;
        delta   = 0;
        sum     = 0;
        sat_err = '0;
        for (int r = 0; r < NREG; r++) begin
            delta = 0;
            if (r != 0) begin
                if (inc_en && inc_dst == creg_addr_t'(r)) delta = delta + 1;
                if (wb_dec && wb_dst  == creg_addr_t'(r)) delta = delta - 1;
                if (fl_dec && fl_dst  == creg_addr_t'(r)) delta = delta - 1;
            end
            sum = int'(cnt[r]) + delta;
            if (sum < 0) begin
                cnt_nxt[r] = '0;
                sat_err[r] = 1'b1;
            end else if (sum > CMAX) begin
                cnt_nxt[r] = cnt[r];
                sat_err[r] = 1'b1;
            end else begin
                cnt_nxt[r] = CNT_W'(sum);
            end
        end
    end

    // Counter array; x0 never moves because its delta is always zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
        end
    end

    // Pending bit per register: some writer is still in flight
    always_comb begin
        pending = '0;
        for (int r = 0; r < NREG; r++) pending[r] = (cnt[r] != '0);
    end

    // A counter under- or overflow means the pipeline lost track of a writer
    always @(posedge clk) begin
        if (!reset) assert (sat_err == '0);
    end

endmodule

// File: rtl/fwd_source.sv
// rtl/fwd_source.sv - EX/MEM forwarding bus producer with decode stall generation
module fwd_source
    import fwd_source_pkg::*;
#(
    parameter int NREG  = NREG_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    fwd_source_if.master     fwd,
    input  logic             id_fire,
    input  logic             id_wen,
    input  creg_addr_t       id_dst,
    input  fwd_data_t        ex_res,
    input  logic             ex_is_load,
    input  logic             ex_busy,
    input  fwd_data_t        mem_res,
    input  logic             wb_valid,
    input  creg_addr_t       wb_dst,
    input  logic             flush,
    input  logic             flush_ex_wen,
    input  creg_addr_t       flush_ex_dst,
    output logic [NREG-1:0]  pending
);

    fwd_data_t ex_bus;
    fwd_data_t mem_bus;
    logic      cov_rs1;
    logic      cov_rs2;
    logic      hit_a;
    logic      hit_b;
    logic      hit_c;
    logic      stall_raw;
    logic      stall;
    logic      inc_en;
    logic      wb_dec;
    logic      fl_dec;

    // Bus values: EX hides loads and x0; MEM yields to a younger EX write of the same register
    always_comb begin
        ex_bus        = ex_res;
        ex_bus.valid  = ex_res.valid && !ex_is_load && (ex_res.dst != '0);
        mem_bus       = mem_res;
        mem_bus.valid = mem_res.valid && (mem_res.dst != '0)
                        && !(ex_res.valid && (ex_res.dst == mem_res.dst));
    end

    // Operand coverage: x0, either bus, or the write-first register file port
    always_comb begin
        cov_rs1 = (fwd.id_rs1 == '0) || bus_hit(ex_bus, fwd.id_rs1)
                  || bus_hit(mem_bus, fwd.id_rs1) || (wb_valid && wb_dst == fwd.id_rs1);
        cov_rs2 = (fwd.id_rs2 == '0) || bus_hit(ex_bus, fwd.id_rs2)
                  || bus_hit(mem_bus, fwd.id_rs2) || (wb_valid && wb_dst == fwd.id_rs2);
    end

    // Stall terms; a load in EX always costs a cycle even if MEM could have served it
    always_comb begin
        hit_a     = pending[fwd.id_rs1] && !cov_rs1;
        hit_b     = fwd.id_use_rs2 && pending[fwd.id_rs2] && !cov_rs2;
        hit_c     = ex_is_load && (ex_res.dst != '0)
                    && ((ex_res.dst == fwd.id_rs1)
                        || (fwd.id_use_rs2 && ex_res.dst == fwd.id_rs2));
        stall_raw = fwd.id_valid && (ex_busy || hit_a || hit_b || hit_c);
        stall     = stall_raw && !flush;
    end

    // Scoreboard events: issue only when decode really advances and nothing is being squashed
    always_comb begin
        inc_en = id_fire && id_wen && (id_dst != '0) && !stall && !flush;
        wb_dec = wb_valid && (wb_dst != '0);
        fl_dec = flush && flush_ex_wen && (flush_ex_dst != '0);
    end

    fwd_scoreboard #(
        .NREG  (NREG),
        .CNT_W (CNT_W)
    ) u_scoreboard (
        .clk     (clk),
        .reset   (reset),
        .inc_en  (inc_en),
        .inc_dst (id_dst),
        .wb_dec  (wb_dec),
        .wb_dst  (wb_dst),
        .fl_dec  (fl_dec),
        .fl_dst  (flush_ex_dst),
        .pending (pending)
    );

    // Outputs are quiet while reset is held so consumers see a clean state immediately
    always_comb begin
        fwd.ex_fwd   = reset ? '0   : ex_bus;
        fwd.mem_fwd  = reset ? '0   : mem_bus;
        fwd.stall_id = reset ? 1'b0 : stall;
    end

endmodule

// File: tb/tb_fwd_source.sv
// tb/tb_fwd_source.sv - table-driven self-checking bench for fwd_source
module tb_fwd_source;
    import fwd_source_pkg::*;

    logic        clk;
    logic        reset;
    logic        id_fire, id_wen, ex_is_load, ex_busy, wb_valid, flush, flush_ex_wen;
    creg_addr_t  id_dst, wb_dst, flush_ex_dst;
    fwd_data_t   ex_res, mem_res;
    logic [31:0] pending;

    fwd_source_if fif ();

    fwd_source dut (
        .clk          (clk),
        .reset        (reset),
        .fwd          (fif),
        .id_fire      (id_fire),
        .id_wen       (id_wen),
        .id_dst       (id_dst),
        .ex_res       (ex_res),
        .ex_is_load   (ex_is_load),
        .ex_busy      (ex_busy),
        .mem_res      (mem_res),
        .wb_valid     (wb_valid),
        .wb_dst       (wb_dst),
        .flush        (flush),
        .flush_ex_wen (flush_ex_wen),
        .flush_ex_dst (flush_ex_dst),
        .pending      (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        id_valid;
        creg_addr_t  rs1, rs2;
        logic        use2;
        logic        fire, wen;
        creg_addr_t  dst;
        fwd_data_t   ex_res;
        logic        ex_ld, busy;
        fwd_data_t   mem_res;
        logic        wb_v;
        creg_addr_t  wb_dst;
        logic        fl, fl_wen;
        creg_addr_t  fl_dst;
        logic        e_ex, e_mem, e_stall;
        logic [31:0] e_pend;
    } vec_t;

    vec_t t;
    vec_t vq[$];
    vec_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    function automatic fwd_data_t fd(input logic v, input creg_addr_t d, input word_t x);
        fwd_data_t r;
        r.valid = v;
        r.dst   = d;
        r.data  = x;
        return r;
    endfunction

    function automatic logic [31:0] pb(input int n);
        logic [31:0] one;
        one = 32'd1;
        return one << n;
    endfunction

    // Row builders operate on the row under construction
    task automatic nw();
        t = '{default: '0};
    endtask
    task automatic dec(input logic v, input creg_addr_t a, input creg_addr_t b, input logic u);
        t.id_valid = v; t.rs1 = a; t.rs2 = b; t.use2 = u;
    endtask
    task automatic iss(input logic f, input logic w, input creg_addr_t d);
        t.fire = f; t.wen = w; t.dst = d;
    endtask
    task automatic exr(input fwd_data_t r, input logic ld, input logic busy);
        t.ex_res = r; t.ex_ld = ld; t.busy = busy;
    endtask
    task automatic memr(input fwd_data_t r);
        t.mem_res = r;
    endtask
    task automatic wbk(input logic v, input creg_addr_t d);
        t.wb_v = v; t.wb_dst = d;
    endtask
    task automatic flu(input logic f, input logic w, input creg_addr_t d);
        t.fl = f; t.fl_wen = w; t.fl_dst = d;
    endtask
    task automatic row(input logic ev, input logic mv, input logic st, input logic [31:0] pend);
        t.e_ex = ev; t.e_mem = mv; t.e_stall = st; t.e_pend = pend;
        vq.push_back(t);
    endtask

    task automatic drive(input vec_t v);
        fif.id_valid   = v.id_valid;
        fif.id_rs1     = v.rs1;
        fif.id_rs2     = v.rs2;
        fif.id_use_rs2 = v.use2;
        id_fire        = v.fire;
        id_wen         = v.wen;
        id_dst         = v.dst;
        ex_res         = v.ex_res;
        ex_is_load     = v.ex_ld;
        ex_busy        = v.busy;
        mem_res        = v.mem_res;
        wb_valid       = v.wb_v;
        wb_dst         = v.wb_dst;
        flush          = v.fl;
        flush_ex_wen   = v.fl_wen;
        flush_ex_dst   = v.fl_dst;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_row(input int k, input vec_t v);
        fwd_data_t ee, em;
        ee = fd(v.e_ex, v.ex_res.dst, v.ex_res.data);
        em = fd(v.e_mem, v.mem_res.dst, v.mem_res.data);
        chk($sformatf("row%0d ex_fwd", k), 64'(fif.ex_fwd), 64'(ee));
        chk($sformatf("row%0d mem_fwd", k), 64'(fif.mem_fwd), 64'(em));
        chk($sformatf("row%0d stall_id", k), 64'(fif.stall_id), 64'(v.e_stall));
        chk($sformatf("row%0d pending", k), 64'(pending), 64'(v.e_pend));
    endtask

    initial begin
        // Vector table; each row sees the counter state left by the rows before it
        nw(); dec(1, 1, 2, 0); iss(1, 1, 5);                                    row(0, 0, 0, 0);
        nw(); dec(1, 5, 0, 0); iss(1, 0, 0); exr(fd(1, 5, 32'hD000_0005), 0, 0); row(1, 0, 0, pb(5));
        nw(); memr(fd(1, 5, 32'hD000_0005));                                    row(0, 1, 0, pb(5));
        nw(); wbk(1, 5);                                                        row(0, 0, 0, pb(5));
        nw(); dec(1, 0, 0, 0); iss(1, 1, 6);                                    row(0, 0, 0, 0);
        nw(); dec(1, 1, 6, 1); iss(1, 1, 10); exr(fd(1, 6, 0), 1, 0);           row(0, 0, 1, pb(6));
        nw(); dec(1, 1, 6, 1); iss(1, 1, 10); memr(fd(1, 6, 32'hD000_0006));    row(0, 1, 0, pb(6));
        nw(); exr(fd(1, 10, 32'hD000_000A), 0, 0); wbk(1, 6);                   row(1, 0, 0, pb(6) | pb(10));
        nw(); wbk(1, 10);                                                       row(0, 0, 0, pb(10));
        nw(); dec(1, 0, 0, 0); iss(1, 1, 7);                                    row(0, 0, 0, 0);
        nw(); dec(1, 7, 0, 0); iss(1, 1, 7); exr(fd(1, 7, 32'hAAAA_0007), 0, 0); row(1, 0, 0, pb(7));
        nw(); dec(1, 7, 0, 0); exr(fd(1, 7, 32'hBBBB_0007), 0, 0);
              memr(fd(1, 7, 32'hAAAA_0007));                                    row(1, 0, 0, pb(7));
        nw(); memr(fd(1, 7, 32'hBBBB_0007)); wbk(1, 7);                         row(0, 1, 0, pb(7));
        nw(); wbk(1, 7);                                                        row(0, 0, 0, pb(7));
        nw(); dec(1, 6, 0, 0); exr(fd(1, 6, 0), 1, 0); memr(fd(1, 6, 32'h66));  row(0, 0, 1, 0);
        nw(); dec(1, 0, 0, 0); iss(1, 1, 8);                                    row(0, 0, 0, 0);
        nw(); exr(fd(1, 8, 0), 1, 0);                                           row(0, 0, 0, pb(8));
        for (int c = 0; c < 4; c++) begin
            nw(); dec(1, 8, 0, 0); memr(fd(0, 8, 0));                           row(0, 0, 1, pb(8));
        end
        nw(); dec(1, 8, 0, 0); memr(fd(1, 8, 32'hD000_0008));                   row(0, 1, 0, pb(8));
        nw(); dec(1, 8, 0, 0); wbk(1, 8);                                       row(0, 0, 0, pb(8));
        nw();                                                                   row(0, 0, 0, 0);
        nw(); dec(1, 0, 0, 0); iss(1, 1, 9);                                    row(0, 0, 0, 0);
        nw(); iss(1, 1, 9); wbk(1, 9);                                          row(0, 0, 0, pb(9));
        nw();                                                                   row(0, 0, 0, pb(9));
        nw(); dec(1, 9, 0, 0); iss(1, 1, 11); flu(1, 1, 9);                     row(0, 0, 0, pb(9));
        nw();                                                                   row(0, 0, 0, 0);
        nw(); dec(1, 0, 0, 0); iss(1, 1, 12);                                   row(0, 0, 0, 0);
        nw(); iss(1, 1, 12);                                                    row(0, 0, 0, pb(12));
        nw(); wbk(1, 12); flu(1, 1, 12);                                        row(0, 0, 0, pb(12));
        nw();                                                                   row(0, 0, 0, 0);
        nw(); dec(1, 1, 2, 1); exr(fd(0, 0, 0), 0, 1);                          row(0, 0, 1, 0);
        nw(); dec(1, 0, 0, 0); iss(1, 1, 0); exr(fd(1, 0, 32'hDEAD_0000), 0, 0); row(0, 0, 0, 0);
        nw();                                                                   row(0, 0, 0, 0);

        // Reset state, with live-looking inputs that must be masked
        reset = 1'b1;
        nw(); dec(1, 3, 0, 0); exr(fd(1, 3, 32'h1234), 1, 1); memr(fd(1, 4, 32'h5678));
        drive(t);
        @(negedge clk);
        chk("reset ex_fwd", 64'(fif.ex_fwd), 64'd0);
        chk("reset mem_fwd", 64'(fif.mem_fwd), 64'd0);
        chk("reset stall_id", 64'(fif.stall_id), 64'd0);
        chk("reset pending", 64'(pending), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Apply the table through the scoreboard queue
        for (int k = 0; k < vq.size(); k++) begin
            drive(vq[k]);
            exp_q.push_back(vq[k]);
            @(negedge clk);
            check_row(k, exp_q.pop_front());
            @(posedge clk); #1;
        end

        // Reset asserted in the middle of a stall
        nw(); dec(1, 0, 0, 0); iss(1, 1, 13);
        drive(t);
        @(posedge clk); #1;
        nw(); dec(1, 13, 0, 0); exr(fd(1, 4, 32'h4444), 0, 0);
        drive(t);
        @(negedge clk);
        chk("midrst pre stall_id", 64'(fif.stall_id), 64'd1);
        chk("midrst pre pending", 64'(pending), 64'(pb(13)));
        chk("midrst pre ex_fwd", 64'(fif.ex_fwd), 64'(fd(1, 4, 32'h4444)));
        #2 reset = 1'b1;
        #1;
        chk("midrst stall_id", 64'(fif.stall_id), 64'd0);
        chk("midrst pending", 64'(pending), 64'd0);
        chk("midrst ex_fwd", 64'(fif.ex_fwd), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("postrst stall_id", 64'(fif.stall_id), 64'd0);
        chk("postrst pending", 64'(pending), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
